// File: rtl/c3aibadapt_sr_tx_shift_if.sv
// Signal bundle for the SR transmit shifter: CSR controls and parallel word in,
// framed serial stream and status out.
interface c3aibadapt_sr_tx_shift_if #(
   parameter int SR_WIDTH = 32
);
   logic                r_sr_enable;
   logic [3:0]          r_sr_gap_cycles;
   logic [SR_WIDTH-1:0] sr_parallel_in;
   logic                sr_data_out;
   logic                sr_load_out;
   logic                sr_frame_done;
   logic                sr_busy;

   modport master (
      output r_sr_enable, r_sr_gap_cycles, sr_parallel_in,
      input  sr_data_out, sr_load_out, sr_frame_done, sr_busy
   );

   modport slave (
      input  r_sr_enable, r_sr_gap_cycles, sr_parallel_in,
      output sr_data_out, sr_load_out, sr_frame_done, sr_busy
   );
endinterface

// File: rtl/c3aibadapt_sr_tx_shift.sv
// SR sideband transmit shifter: captures a parallel word and shifts it out MSB-first
// with load strobe and inter-frame gap. Define C3AIBADAPT_SR_TX_PARITY_EN for a trailing even-parity bit.
module c3aibadapt_sr_tx_shift #(
   parameter int SR_WIDTH  = 32,
   parameter int CNT_WIDTH = 6
) (
   input logic                     sr_clock_tx_osc_clk,
   input logic                     sr_reset_tx_osc_clk_rst_n,
   c3aibadapt_sr_tx_shift_if.slave sr_if
);
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   logic [2:0]          state_r, state_s;
   logic [SR_WIDTH-1:0] shreg_r, shreg_s;
   logic [CNT_WIDTH-1:0] bit_cnt_r, bit_cnt_s;
   logic [CNT_WIDTH-1:0] gap_cnt_r, gap_cnt_s;
   logic                data_r, data_s;
   logic                load_r, load_s;
   logic                done_r, done_s;
   logic                busy_r, busy_s;
   logic                frame_end_s;
   logic                restart_s;

`ifdef C3AIBADAPT_SR_TX_PARITY_EN
   logic                par_r, par_s;

   function automatic logic even_parity(input logic [SR_WIDTH-1:0] word);
      return ^word;
   endfunction
`endif

   // Next-state and next-output decode; outputs are computed one cycle ahead and registered.
   always_comb begin
      state_s     = state_r;
      shreg_s     = shreg_r;
      bit_cnt_s   = bit_cnt_r;
      gap_cnt_s   = gap_cnt_r;
      data_s      = 1'b0;
      load_s      = 1'b0;
      done_s      = 1'b0;
      busy_s      = 1'b0;
      frame_end_s = 1'b0;
      restart_s   = 1'b0;
`ifdef C3AIBADAPT_SR_TX_PARITY_EN
      par_s       = par_r;
`endif
      case (state_r)
         ST_IDLE: begin
            restart_s = 1'b1;
         end
         ST_LOAD: begin
            shreg_s   = {sr_if.sr_parallel_in[SR_WIDTH-2:0], 1'b0};
            data_s    = sr_if.sr_parallel_in[SR_WIDTH-1];
            bit_cnt_s = CNT_WIDTH'(SR_WIDTH - 1);
            busy_s    = 1'b1;
            state_s   = ST_SHIFT;
`ifdef C3AIBADAPT_SR_TX_PARITY_EN
            par_s     = even_parity(sr_if.sr_parallel_in);
`endif
         end
         ST_SHIFT: begin
            if (bit_cnt_r == {CNT_WIDTH{1'b0}}) begin
`ifdef C3AIBADAPT_SR_TX_PARITY_EN
               state_s = ST_PAR;
               data_s  = par_r;
               busy_s  = 1'b1;
`else
               frame_end_s = 1'b1;
`endif
            end else begin
               data_s    = shreg_r[SR_WIDTH-1];
               shreg_s   = {shreg_r[SR_WIDTH-2:0], 1'b0};
               bit_cnt_s = bit_cnt_r - CNT_WIDTH'(1);
               busy_s    = 1'b1;
            end
         end
`ifdef C3AIBADAPT_SR_TX_PARITY_EN
         ST_PAR: begin
            frame_end_s = 1'b1;
         end
`endif
         ST_GAP: begin
            if (gap_cnt_r <= CNT_WIDTH'(1)) begin
               gap_cnt_s = {CNT_WIDTH{1'b0}};
               restart_s = 1'b1;
            end else begin
               gap_cnt_s = gap_cnt_r - CNT_WIDTH'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Gap is sampled only at frame end; a zero gap chains straight into the next LOAD.
      if (frame_end_s) begin
         done_s = 1'b1;
         if (sr_if.r_sr_gap_cycles != 4'd0) begin
            state_s   = ST_GAP;
            gap_cnt_s = CNT_WIDTH'(sr_if.r_sr_gap_cycles);
         end else begin
            restart_s = 1'b1;
         end
      end else begin
         done_s = 1'b0;
      end

      if (restart_s) begin
         if (sr_if.r_sr_enable) begin
            state_s = ST_LOAD;
            load_s  = 1'b1;
            busy_s  = 1'b1;
         end else begin
            state_s = ST_IDLE;
         end
      end else begin
         load_s = 1'b0;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge sr_clock_tx_osc_clk or negedge sr_reset_tx_osc_clk_rst_n) begin
      if (!sr_reset_tx_osc_clk_rst_n) begin
         state_r   <= ST_IDLE;
         shreg_r   <= {SR_WIDTH{1'b0}};
         bit_cnt_r <= {CNT_WIDTH{1'b0}};
         gap_cnt_r <= {CNT_WIDTH{1'b0}};
         data_r    <= 1'b0;
         load_r    <= 1'b0;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
`ifdef C3AIBADAPT_SR_TX_PARITY_EN
         par_r     <= 1'b0;
`endif
      end else begin
         state_r   <= state_s;
         shreg_r   <= shreg_s;
         bit_cnt_r <= bit_cnt_s;
         gap_cnt_r <= gap_cnt_s;
         data_r    <= data_s;
         load_r    <= load_s;
         done_r    <= done_s;
         busy_r    <= busy_s;
`ifdef C3AIBADAPT_SR_TX_PARITY_EN
         par_r     <= par_s;
`endif
      end
   end

   assign sr_if.sr_data_out   = data_r;
   assign sr_if.sr_load_out   = load_r;
   assign sr_if.sr_frame_done = done_r;
   assign sr_if.sr_busy       = busy_r;
endmodule
